// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures high time and rise-to-rise period in microseconds and decodes
// a clamped position offset. Define GLITCH_FILTER_EN to insert a FILTER_LEN-sample glitch filter.
module servo_pwm_capture #(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned MIN_PULSE_US = 500,
  parameter int unsigned MAX_PULSE_US = 2500,
  parameter int unsigned TIMEOUT_US   = 25000,
  parameter int unsigned FILTER_LEN   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        pwm_in,
  output logic [15:0] pulse_us,
  output logic [15:0] period_us,
  output logic [11:0] pos_offset_us,
  output logic        sample_valid,
  output logic        range_err,
  output logic        timeout
);

  localparam int unsigned CLKS_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLKS_PER_US - 1);
  localparam logic [15:0] MIN_US = 16'(MIN_PULSE_US);
  localparam logic [15:0] MAX_US = 16'(MAX_PULSE_US);
  localparam logic [15:0] TO_US  = 16'(TIMEOUT_US);

  typedef enum logic [1:0] {StSeek, StArm, StHigh, StLow} state_e;

  state_e        state_q;
  logic [1:0]    sync_q;
  logic          level;
  logic          pwm_q, pwm_prev_q;
  logic          rise, fall;
  logic [PW-1:0] wp_q, pp_q;
  logic [15:0]   w_q, p_q, lw_q;
  logic          wp_wrap, pp_wrap;
  logic [15:0]   w_inc, p_inc;
  logic [15:0]   clamped, offset_full;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Sync chain resets high so a pulse in flight at reset never looks like a fresh rising edge.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], pwm_in};
  end

`ifdef GLITCH_FILTER_EN
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] filt_cnt_q;
  logic          filt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else if (sync_q[1] == filt_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_q     <= sync_q[1];
      filt_cnt_q <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + FW'(1);
    end
  end

  assign level = filt_q;
`else
  logic unused_filter_len;
  assign unused_filter_len = (FILTER_LEN == 0);
  assign level = sync_q[1];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_q      <= 1'b1;
      pwm_prev_q <= 1'b1;
    end else begin
      pwm_q      <= level;
      pwm_prev_q <= pwm_q;
    end
  end

  assign rise    = pwm_q & ~pwm_prev_q;
  assign fall    = ~pwm_q & pwm_prev_q;
  assign wp_wrap = (wp_q == PRE_MAX);
  assign pp_wrap = (pp_q == PRE_MAX);
  assign w_inc   = wp_wrap ? sat_inc(w_q) : w_q;
  assign p_inc   = pp_wrap ? sat_inc(p_q) : p_q;

  always_comb begin
    clamped = lw_q;
    if (lw_q < MIN_US)      clamped = MIN_US;
    else if (lw_q > MAX_US) clamped = MAX_US;
    offset_full = clamped - MIN_US;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StSeek;
      wp_q          <= '0;
      pp_q          <= '0;
      w_q           <= '0;
      p_q           <= '0;
      lw_q          <= '0;
      pulse_us      <= '0;
      period_us     <= '0;
      pos_offset_us <= '0;
      sample_valid  <= 1'b0;
      range_err     <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;

      // Width counter doubles as the per-phase timer since it restarts on every edge.
      if (!enable || state_q == StSeek) begin
        wp_q <= '0;
        pp_q <= '0;
        w_q  <= '0;
        p_q  <= '0;
      end else begin
        wp_q <= (rise || fall || wp_wrap) ? '0 : wp_q + PW'(1);
        w_q  <= (rise || fall) ? '0 : w_inc;
        pp_q <= (rise || pp_wrap) ? '0 : pp_q + PW'(1);
        p_q  <= rise ? '0 : p_inc;
      end

      if (!enable) begin
        state_q <= StSeek;
      end else begin
        unique case (state_q)
          StSeek: if (!pwm_q) state_q <= StArm;
          StArm:  if (rise) state_q <= StHigh;
          StHigh: begin
            if (w_q >= TO_US) begin
              timeout <= 1'b1;
              state_q <= StSeek;
            end else if (fall) begin
              lw_q    <= w_inc;
              state_q <= StLow;
            end
          end
          StLow: begin
            if (w_q >= TO_US) begin
              timeout <= 1'b1;
              state_q <= StSeek;
            end else if (rise) begin
              pulse_us      <= lw_q;
              period_us     <= p_inc;
              pos_offset_us <= offset_full[11:0];
              range_err     <= (lw_q < MIN_US) || (lw_q > MAX_US);
              timeout       <= 1'b0;
              sample_valid  <= 1'b1;
              state_q       <= StHigh;
            end
          end
          default: state_q <= StSeek;
        endcase
      end
    end
  end

endmodule
